branch_predict_unit: RTL
========================

# branch_predict_unit

Parametrised successor to `branch_unit`: resolves conditional branches and jumps in EX with the same compare semantics. It adds a DEPTH-entry branch history table of 2-bit saturating counters that supplies taken/not-taken predictions to IF. It detects mispredictions and issues a registered one-cycle flush with the corrected PC, and it keeps saturating branch and mispredict statistics counters. It sits between the ALU/EX stage and the PC/fetch logic.

## Interface
- `XLEN`, 32, data/address width
- `DEPTH`, 64, BHT entries; power of two, 2..1024
- `CNT_W`, 16, statistics counter width
- `clk` input 1, single clock, rising edge
- `rst_n` input 1, asynchronous, active-low reset
- `pred_pc` input XLEN, fetch PC to predict
- `pred_taken` output 1, combinational prediction: counter MSB of entry `pred_pc[IDX+1:2]`, where IDX=$clog2(DEPTH)
- `res_valid` input 1, EX resolves a control-transfer instruction this cycle
- `res_pc` input XLEN, PC of the resolving instruction
- `res_target` input XLEN, computed branch/jump target
- `alu_result` input XLEN, ALU compare result
- `cmp_opcode` input 3, `ALU_CMP_*` code
- `pc_jump` input 1, unconditional jump
- `res_pred_taken` input 1, prediction that travelled with the instruction
- `branch` output 2, combinational {pc_jump, cond_taken}, gated by res_valid
- `flush` output 1, registered mispredict pulse
- `flush_pc` output XLEN, registered corrected PC
- `br_count` output CNT_W, resolved branches (res_valid with pc_jump=0)
- `mp_count` output CNT_W, mispredicts

## Operation
- cond_taken, defined only when res_valid=1 and pc_jump=0:
  - EQ: alu_result==0
  - NE: alu_result!=0
  - LT/LTU: alu_result[0]==1
  - GE/GEU: alu_result[0]==0
  - Any other code: 0
- actual_taken = pc_jump | cond_taken.
- branch=2'b00 whenever res_valid=0.
- BHT update: on res_valid=1 with pc_jump=0, entry `res_pc[IDX+1:2]` moves toward taken or not-taken.
  - Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
  - The counter saturates at 00 and 11.
  - Jumps do not touch the BHT.
- Mispredict = res_valid & (actual_taken != res_pred_taken).
  - A jump with res_pred_taken=0 is a mispredict.
  - flush_pc = actual_taken ? res_target : res_pc+4, with modulo-2^XLEN wrap.
- Statistics:
  - br_count increments per conditional resolve.
  - mp_count increments per mispredict, including jumps.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Same-cycle read and update of one index: pred_taken returns the pre-update value. There is no bypass.

## Timing
- Reset (asynchronous, rst_n=0):
  - All BHT entries = 01 (WNT).
  - flush=0, flush_pc=0, br_count=0, mp_count=0.
  - pred_taken therefore reads 0 after reset.
- pred_taken and branch: 0-cycle combinational.
- BHT and statistics update at the rising edge ending the res_valid cycle.
- flush: asserted in the cycle after the mispredicting res_valid, for exactly one cycle, with flush_pc valid alongside.
  - Back-to-back mispredicts give back-to-back flush pulses, each carrying its own flush_pc.
- Reset asserted mid-operation aborts a pending flush immediately. No flush is emitted after rst_n rises.
- No handshake or backpressure: res_valid is a one-cycle strobe per instruction.

## Structure
- Compare codes come from the shared `inc/alu_opcode.v` (`ALU_CMP_*`).
- New shared `inc/branch_pred.v` holds the counter-state macros (`BP_SNT`, `BP_WNT`, `BP_WT`, `BP_ST`) and the reset state.
- One sub-module, `branch_sat_counter`: 2-bit next-state function, input `taken`, with saturation.
- BHT is a register array (async reset required), not inferred RAM.

## Test plan
- Reset, pred_pc=0x100 → pred_taken=0, flush=0, counters 0.
- res_valid, res_pc=0x100, EQ, alu_result=0, res_pred_taken=0, res_target=0x80 → branch=01. Next cycle flush=1, flush_pc=0x80, br=1, mp=1, pred_taken at 0x100 =1 (WT).
- Second identical resolve with res_pred_taken=1 → no flush, entry=ST. Then two not-taken (NE, alu_result=0, res_pred_taken=1) → SNT... wait: ST→WT→WNT, pred_taken=0. Two flushes each with flush_pc=0x104.
- pc_jump=1, res_pred_taken=0, res_target=0x2000 → branch=10, flush with flush_pc=0x2000, BHT unchanged, br unchanged.
- res_pc=0xFFFFFFFC not-taken, mispredicted → flush_pc=0x00000000 (wrap). CNT_W=2 with 5 mispredicts → mp_count=3.
- rst_n low in the cycle between mispredict and flush → flush never asserts, BHT back to WNT.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: compare codes, BHT counter states and compare decode
package branch_predict_unit_pkg;
    localparam logic [2:0] ALU_CMP_EQ  = 3'd0;
    localparam logic [2:0] ALU_CMP_NE  = 3'd1;
    localparam logic [2:0] ALU_CMP_LT  = 3'd2;
    localparam logic [2:0] ALU_CMP_GE  = 3'd3;
    localparam logic [2:0] ALU_CMP_LTU = 3'd4;
    localparam logic [2:0] ALU_CMP_GEU = 3'd5;
    localparam logic [1:0] BP_SNT   = 2'b00;
    localparam logic [1:0] BP_WNT   = 2'b01;
    localparam logic [1:0] BP_WT    = 2'b10;
    localparam logic [1:0] BP_ST    = 2'b11;
    localparam logic [1:0] BP_RESET = BP_WNT;

    function automatic logic cmp_taken(input logic [2:0] op, input logic zero, input logic lsb);
        return (op == ALU_CMP_EQ) ? zero :
               (op == ALU_CMP_NE) ? ~zero :
               (op == ALU_CMP_LT || op == ALU_CMP_LTU) ? lsb :
               (op == ALU_CMP_GE || op == ALU_CMP_GEU) ? ~lsb : 1'b0;
    endfunction
endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// branch_sat_counter: 2-bit saturating taken/not-taken counter next state
module branch_sat_counter
    import branch_predict_unit_pkg::*;
(
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next
);
    always_comb
        next = taken ? ((state == BP_ST) ? BP_ST : state + 2'd1)
                     : ((state == BP_SNT) ? BP_SNT : state - 2'd1);
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: branch resolve, 2-bit BHT prediction, mispredict flush and stats
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  res_pc,
    input  logic [XLEN-1:0]  res_target,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [2:0]       cmp_opcode,
    input  logic             pc_jump,
    input  logic             res_pred_taken,
    output logic [1:0]       branch,
    output logic             flush,
    output logic [XLEN-1:0]  flush_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);
    localparam int IDX = $clog2(DEPTH);

    logic [1:0]     bht [DEPTH];
    logic [IDX-1:0] pidx, ridx;
    logic [1:0]     cur, nxt;
    logic           is_cond, cond_taken, actual_taken, mispredict;
    logic           unused_pc_bits;

    assign pidx           = pred_pc[IDX+1:2];
    assign ridx           = res_pc[IDX+1:2];
    assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX+2], pred_pc[1:0]};
    assign pred_taken     = bht[pidx][1];
    assign cur            = bht[ridx];

    always_comb begin
        is_cond      = res_valid & ~pc_jump;
        cond_taken   = is_cond & cmp_taken(cmp_opcode, alu_result == '0, alu_result[0]);
        actual_taken = pc_jump | cond_taken;
        mispredict   = res_valid & (actual_taken != res_pred_taken);
        branch       = res_valid ? {pc_jump, cond_taken} : 2'b00;
    end

    branch_sat_counter u_ctr (.state(cur), .taken(cond_taken), .next(nxt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) bht[i] <= BP_RESET;
            flush    <= 1'b0;
            flush_pc <= '0;
            br_count <= '0;
            mp_count <= '0;
        end else begin
            if (is_cond) bht[ridx] <= nxt;
            flush <= mispredict;
            if (mispredict) flush_pc <= actual_taken ? res_target : res_pc + XLEN'(4);
            if (is_cond && !(&br_count)) br_count <= br_count + 1'b1;
            if (mispredict && !(&mp_count)) mp_count <= mp_count + 1'b1;
        end
    end
endmodule
